// File: rtl/dual_port_mem_model_if.sv
// dual_port_mem_model_if: instruction-fetch port A and data port B of the behavioural memory
interface dual_port_mem_model_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
);
    logic                    a_req;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic                    a_stall;
    logic [DATA_WIDTH-1:0]   a_rdata;
    logic                    a_rvalid;
    logic                    b_req;
    logic                    b_we;
    logic [DATA_WIDTH/8-1:0] b_wstrb;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_wdata;
    logic                    b_stall;
    logic [DATA_WIDTH-1:0]   b_rdata;
    logic                    b_rvalid;

    modport master (
        output a_req, a_addr, a_stall, b_req, b_we, b_wstrb, b_addr, b_wdata, b_stall,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid
    );

    modport slave (
        input  a_req, a_addr, a_stall, b_req, b_we, b_wstrb, b_addr, b_wdata, b_stall,
        output a_rdata, a_rvalid, b_rdata, b_rvalid
    );
endinterface

// File: rtl/dual_port_mem_model.sv
// dual_port_mem_model: dual-port behavioural memory with stallable per-port read pipelines
module dual_port_mem_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input logic clk,
    input logic rst,
    dual_port_mem_model_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int L  = READ_LATENCY;

    if (L < 1 || L > 4) begin : g_bad_latency
        $error("READ_LATENCY %0d outside 1..4", L);
    end

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic a_acc, b_acc;
    logic [DATA_WIDTH-1:0] b_cur, b_merge;
    logic [L-1:0] a_v, b_v, a_vn, b_vn;
    logic [L-1:0][DATA_WIDTH-1:0] a_d, b_d, a_dn, b_dn;

    assign a_acc = bus.a_req & ~bus.a_stall & ~rst;
    assign b_acc = bus.b_req & ~bus.b_stall & ~rst;
    assign b_cur = mem[bus.b_addr];

    // reads pass the current word through, so the echo is always the post-write word
    for (genvar i = 0; i < NB; i++) begin : g_merge
        assign b_merge[8*i +: 8] = bus.b_we && bus.b_wstrb[i] ? bus.b_wdata[8*i +: 8] : b_cur[8*i +: 8];
    end

    always_ff @(posedge clk)
        if (b_acc && bus.b_we) mem[bus.b_addr] <= b_merge;

    // output stage keeps its data across bubbles; inner stages shift freely
    always_comb begin
        a_vn = L'({a_v, a_acc});
        b_vn = L'({b_v, b_acc});
        a_dn = (L*DATA_WIDTH)'({a_d, mem[bus.a_addr]});
        b_dn = (L*DATA_WIDTH)'({b_d, b_merge});
        if (!a_vn[L-1]) a_dn[L-1] = a_d[L-1];
        if (!b_vn[L-1]) b_dn[L-1] = b_d[L-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_v <= '0;
            a_d <= '0;
            b_v <= '0;
            b_d <= '0;
        end else begin
            if (!bus.a_stall) begin
                a_v <= a_vn;
                a_d <= a_dn;
            end
            if (!bus.b_stall) begin
                b_v <= b_vn;
                b_d <= b_dn;
            end
        end
    end

    assign bus.a_rdata  = a_d[L-1];
    assign bus.a_rvalid = a_v[L-1];
    assign bus.b_rdata  = b_d[L-1];
    assign bus.b_rvalid = b_v[L-1];
endmodule

// File: tb/tb_dual_port_mem_model.sv
// tb_dual_port_mem_model: three latencies driven in lockstep against a response-ageing reference model
module tb_dual_port_mem_model;
    logic clk = 1'b0;
    logic rst, a_req, a_stall, b_req, b_we, b_stall;
    logic [3:0] a_addr, b_addr, b_wstrb;
    logic [31:0] b_wdata;
    logic [31:0] ord [3][2];
    logic        orv [3][2];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{1, 2, 4};

    logic [31:0] m [16];
    bit          used [3][2][8];
    int          age  [3][2][8];
    logic [31:0] dat  [3][2][8];
    logic        erv  [3][2];
    logic [31:0] erd  [3][2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_d
        localparam int LAT = g == 0 ? 1 : g == 1 ? 2 : 4;
        dual_port_mem_model_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
        assign bus.a_req   = a_req;
        assign bus.a_addr  = a_addr;
        assign bus.a_stall = a_stall;
        assign bus.b_req   = b_req;
        assign bus.b_we    = b_we;
        assign bus.b_wstrb = b_wstrb;
        assign bus.b_addr  = b_addr;
        assign bus.b_wdata = b_wdata;
        assign bus.b_stall = b_stall;
        dual_port_mem_model #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(LAT)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        assign ord[g][0] = bus.a_rdata;
        assign orv[g][0] = bus.a_rvalid;
        assign ord[g][1] = bus.b_rdata;
        assign orv[g][1] = bus.b_rvalid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // a response becomes visible once it has survived lat non-stalled edges
    task automatic port_step(input int j, input int p, input logic acc, input logic s, input logic [31:0] w);
        bit placed = 0;
        if (rst) begin
            for (int k = 0; k < 8; k++) used[j][p][k] = 0;
            erv[j][p] = 0;
            erd[j][p] = 0;
        end else if (!s) begin
            for (int k = 0; k < 8; k++) if (used[j][p][k]) age[j][p][k]++;
            for (int k = 0; k < 8; k++)
                if (acc && !placed && !used[j][p][k]) begin
                    used[j][p][k] = 1;
                    age[j][p][k] = 1;
                    dat[j][p][k] = w;
                    placed = 1;
                end
            erv[j][p] = 0;
            for (int k = 0; k < 8; k++)
                if (used[j][p][k] && age[j][p][k] == lat[j]) begin
                    erv[j][p] = 1;
                    erd[j][p] = dat[j][p][k];
                    used[j][p][k] = 0;
                end
        end
    endtask

    task automatic step();
        logic aacc, bacc;
        logic [31:0] aw, bw;
        aacc = !rst && !a_stall && a_req;
        bacc = !rst && !b_stall && b_req;
        aw = m[a_addr];
        bw = m[b_addr];
        if (b_we) for (int i = 0; i < 4; i++) if (b_wstrb[i]) bw[8*i +: 8] = b_wdata[8*i +: 8];
        for (int j = 0; j < 3; j++) begin
            port_step(j, 0, aacc, a_stall, aw);
            port_step(j, 1, bacc, b_stall, bw);
        end
        if (bacc && b_we) m[b_addr] = bw;
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        @(negedge clk);
        for (int j = 0; j < 3; j++)
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("L%0d_%s_rvalid", lat[j], p != 0 ? "b" : "a"), 32'(orv[j][p]), 32'(erv[j][p]));
                chk($sformatf("L%0d_%s_rdata", lat[j], p != 0 ? "b" : "a"), ord[j][p], erd[j][p]);
            end
    endtask

    task automatic idle();
        rst = 0; a_req = 0; a_stall = 0; a_addr = 0;
        b_req = 0; b_we = 0; b_stall = 0; b_addr = 0; b_wstrb = 0; b_wdata = 0;
    endtask

    task automatic wr(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] s);
        b_req = 1; b_we = 1; b_addr = ad; b_wdata = d; b_wstrb = s;
    endtask

    task automatic rd_a(input logic [3:0] ad);
        a_req = 1; a_addr = ad;
    endtask

    task automatic rd_b(input logic [3:0] ad);
        b_req = 1; b_we = 0; b_addr = ad;
    endtask

    initial begin
        logic [31:0] e [3];
        logic [31:0] got [$];
        int cnt;
        for (int j = 0; j < 3; j++) for (int p = 0; p < 2; p++) begin
            erv[j][p] = 0;
            erd[j][p] = 0;
            for (int k = 0; k < 8; k++) used[j][p][k] = 0;
        end
        idle();
        rst = 1;
        cyc();
        cyc();
        for (int i = 0; i < 16; i++) begin
            idle();
            wr(4'(i), $urandom, 4'hf);
            cyc();
        end

        // reset with requests pending: no write, outputs cleared
        idle();
        rst = 1;
        rd_a(2);
        wr(2, 32'h0, 4'hf);
        cyc();
        cyc();
        for (int j = 0; j < 3; j++) for (int p = 0; p < 2; p++) begin
            chk("rst_rvalid", 32'(orv[j][p]), 0);
            chk("rst_rdata", ord[j][p], 0);
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            rd_a(4'(i));
            cyc();
        end
        idle();
        repeat (4) cyc();

        idle();
        wr(5, 32'hDEADBEEF, 4'hf);
        cyc();
        idle();
        repeat (4) cyc();
        for (int n = 1; n <= 5; n++) begin
            idle();
            if (n == 1) rd_a(5);
            cyc();
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("lat%0d_n%0d_rvalid", lat[j], n), 32'(orv[j][0]), 32'(n == lat[j]));
                if (n == lat[j]) chk($sformatf("lat%0d_rdata", lat[j]), ord[j][0], 32'hDEADBEEF);
            end
        end

        idle();
        wr(3, 32'h11223344, 4'hf);
        cyc();
        idle();
        wr(3, 32'hAABBCCDD, 4'b0101);
        cyc();
        idle();
        cyc();
        chk("strb_echo_valid", 32'(orv[1][1]), 1);
        chk("strb_echo", ord[1][1], 32'h11BB33DD);
        idle();
        rd_a(3);
        cyc();
        idle();
        cyc();
        chk("strb_read_valid", 32'(orv[1][0]), 1);
        chk("strb_read", ord[1][0], 32'h11BB33DD);

        idle();
        wr(7, 32'h1, 4'hf);
        cyc();
        idle();
        rd_a(7);
        wr(7, 32'h2, 4'hf);
        cyc();
        idle();
        cyc();
        chk("coll_a_old", ord[1][0], 32'h1);
        chk("coll_b_new", ord[1][1], 32'h2);
        idle();
        rd_a(7);
        cyc();
        idle();
        cyc();
        chk("coll_a_after", ord[1][0], 32'h2);

        // B stream 1,2,3 with a held write during a 3-cycle stall, A streaming throughout
        e[0] = m[1];
        e[1] = m[2];
        e[2] = m[3];
        for (int c = 0; c < 10; c++) begin
            idle();
            rd_a(4'(c));
            if (c == 0) rd_b(1);
            if (c == 1) rd_b(2);
            if (c >= 2 && c <= 4) begin
                b_stall = 1;
                wr(2, 32'hFFFFFFFF, 4'hf);
            end
            if (c == 5) rd_b(3);
            cyc();
            if (c >= 2 && c <= 4) chk("stall_hold", ord[1][1], e[0]);
            if (orv[1][1] && !b_stall) got.push_back(ord[1][1]);
        end
        chk("stall_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("stall_order%0d", i), got[i], e[i]);
        idle();
        rd_a(2);
        cyc();
        idle();
        cyc();
        chk("stall_nowrite", ord[1][0], e[1]);

        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c < 2) rd_a(4'(c));
            if (c == 2) begin
                rst = 1;
                rd_a(9);
            end
            cyc();
            if (c >= 2) cnt += int'(orv[1][0]) + int'(orv[2][0]);
        end
        chk("midrst_no_resp", cnt, 0);

        repeat (600) begin
            rst = ($urandom % 64) == 0;
            a_req = 1'($urandom);
            a_addr = 4'($urandom);
            a_stall = ($urandom % 4) == 0;
            b_req = 1'($urandom);
            b_we = 1'($urandom);
            b_addr = 4'($urandom);
            b_wstrb = 4'($urandom);
            b_wdata = $urandom;
            b_stall = ($urandom % 4) == 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
